// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared types and default constants for the programmable LUT array.
//   state_e          - configuration FSM state (UNCFG: some table unloaded, RUN: all loaded)
//   N_IN_DEFAULT     - default number of Boolean inputs
//   N_OUT_DEFAULT    - default number of output functions
//   OUT_REG_DEFAULT  - default output stage style (1 = registered)
package prog_lut_pkg;

    localparam int unsigned N_IN_DEFAULT    = 2;
    localparam int unsigned N_OUT_DEFAULT   = 6;
    localparam int unsigned OUT_REG_DEFAULT = 1;

    typedef enum logic [0:0] {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/prog_lut_array_lut_row.sv
// lut_row: one programmable truth-table row and its minterm multiplexer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   wr_en     - load wr_tt into the row
//   clr       - clear the row to all zeros (wins over wr_en)
//   wr_tt     - truth table, bit k = function value for minterm k
//   sel_x     - input vector selecting the minterm
//   f         - table value at minterm sel_x
module lut_row #(
    parameter int unsigned N_IN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 clr,
    input  logic [2**N_IN-1:0]   wr_tt,
    input  logic [N_IN-1:0]      sel_x,
    output logic                 f
);

    logic [2**N_IN-1:0] tt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q <= '0;
        end else if (clr) begin
            tt_q <= '0;
        end else if (wr_en) begin
            tt_q <= wr_tt;
        end
    end

    assign f = tt_q[sel_x];

endmodule

// File: rtl/prog_lut_array.sv
// prog_lut_array: N_OUT programmable Boolean functions of N_IN inputs with
// ready/valid configuration and evaluation interfaces.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   cfg_valid/cfg_ready           - table write handshake (cfg_sel, cfg_tt)
//   cfg_clr                       - clears all tables and loaded flags
//   in_valid/in_ready, in_x       - evaluation request
//   out_valid/out_ready, out_f    - evaluation result, bit j = table[j][in_x]
//   all_loaded                    - every table written since last clear/reset
//   out_par                       - XOR of out_f, present only with PROG_LUT_PARITY_EN
// Build option: define PROG_LUT_PARITY_EN to add the out_par output.
module prog_lut_array
    import prog_lut_pkg::*;
#(
    parameter int unsigned N_IN    = N_IN_DEFAULT,
    parameter int unsigned N_OUT   = N_OUT_DEFAULT,
    parameter int unsigned OUT_REG = OUT_REG_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cfg_valid,
    output logic                                     cfg_ready,
    input  logic [$clog2(N_OUT > 1 ? N_OUT : 2)-1:0] cfg_sel,
    input  logic [2**N_IN-1:0]                       cfg_tt,
    input  logic                                     cfg_clr,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [N_IN-1:0]                          in_x,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [N_OUT-1:0]                         out_f,
    output logic                                     all_loaded
`ifdef PROG_LUT_PARITY_EN
    ,
    output logic                                     out_par
`endif
);

    state_e             state_q;
    logic [N_OUT-1:0]   loaded_q;
    logic [N_OUT-1:0]   loaded_d;
    logic [N_OUT-1:0]   wr_en;
    logic [N_OUT-1:0]   lut_f;
    logic               cfg_fire;
    logic               run;

    assign run        = (state_q == RUN);
    assign all_loaded = run;
    // A pending result blocks writes so it can never mix old and new tables.
    assign cfg_ready  = !out_valid;
    // A same-cycle clear drops the write.
    assign cfg_fire   = cfg_valid && cfg_ready && !cfg_clr;

    // Out-of-range selects match no row and are silently ignored.
    always_comb begin
        wr_en = '0;
        for (int j = 0; j < int'(N_OUT); j++) begin
            wr_en[j] = cfg_fire && (32'(cfg_sel) == j);
        end
        loaded_d = cfg_clr ? '0 : (loaded_q | wr_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNCFG;
            loaded_q <= '0;
        end else begin
            loaded_q <= loaded_d;
            if (cfg_clr) begin
                state_q <= UNCFG;
            end else if (&loaded_d) begin
                state_q <= RUN;
            end
        end
    end

    for (genvar j = 0; j < int'(N_OUT); j++) begin : g_row
        lut_row #(
            .N_IN(N_IN)
        ) u_row (
            .clk   (clk),
            .rst   (rst),
            .wr_en (wr_en[j]),
            .clr   (cfg_clr),
            .wr_tt (cfg_tt),
            .sel_x (in_x),
            .f     (lut_f[j])
        );
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             valid_q;
        logic [N_OUT-1:0] f_q;
        logic             in_fire;

        assign in_ready = run && !cfg_valid && (!valid_q || out_ready);
        assign in_fire  = in_valid && in_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                f_q     <= '0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                f_q     <= lut_f;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end

        assign out_valid = valid_q;
        assign out_f     = f_q;
    end else begin : g_out_comb
        // Same handshake with the register removed; out_valid never depends on in_ready.
        assign out_valid = in_valid && run && !cfg_valid;
        assign in_ready  = run && !cfg_valid && (!in_valid || out_ready);
        assign out_f     = out_valid ? lut_f : '0;
    end

`ifdef PROG_LUT_PARITY_EN
    assign out_par = ^out_f;
`endif

endmodule

// File: tb/tb_prog_lut_array.sv
// tb_prog_lut_array: scoreboard bench for prog_lut_array at default parameters.
// Expected results are queued when an evaluation is accepted and compared
// when the DUT hands a result downstream.
module tb_prog_lut_array;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_sel;
    logic [3:0] cfg_tt;
    logic       cfg_clr;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_f;
    logic       all_loaded;
`ifdef PROG_LUT_PARITY_EN
    logic       out_par;
`endif

    always #5 clk = ~clk;

    prog_lut_array #(
        .N_IN    (2),
        .N_OUT   (6),
        .OUT_REG (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_tt     (cfg_tt),
        .cfg_clr    (cfg_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .all_loaded (all_loaded)
`ifdef PROG_LUT_PARITY_EN
        ,
        .out_par    (out_par)
`endif
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_out = 0;
    int         cyc   = 0;
    logic [5:0] sb[$];
    logic [3:0] tbl[6];
    logic [5:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] model_f(input logic [1:0] x);
        logic [5:0] r;
        for (int j = 0; j < 6; j++) r[j] = tbl[j][x];
        return r;
    endfunction

    // Scoreboard consumer: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("out_f", 32'(out_f), 32'(mon_exp));
`ifdef PROG_LUT_PARITY_EN
                check("out_par", 32'(out_par), 32'(^mon_exp));
`endif
                n_out++;
            end
        end
    end

    task automatic eval_exp(input logic [1:0] x, input logic [5:0] exp);
        bit done = 0;
        in_valid = 1'b1;
        in_x     = x;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("in_accept_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic eval(input logic [1:0] x);
        eval_exp(x, model_f(x));
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [3:0] tt);
        bit done = 0;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_tt    = tt;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cfg_ready) begin
                if (sel < 6 && !cfg_clr) tbl[sel] = tt;
                done = 1;
            end
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        if (!done) check("cfg_accept_timeout", 32'(cfg_ready), 32'd1);
    endtask

    task automatic drain();
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         c0;
        int         o0;
        logic [5:0] hold_exp;

        for (int j = 0; j < 6; j++) tbl[j] = '0;
        rst = 1'b1; cfg_valid = 0; cfg_sel = 0; cfg_tt = 0; cfg_clr = 0;
        in_valid = 1'b1; in_x = 0; out_ready = 1'b1;

        // Reset values
        #1;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_all_loaded", 32'(all_loaded), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_f", 32'(out_f), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("uncfg_in_ready", 32'(in_ready), 32'd0);
            check("uncfg_out_valid", 32'(out_valid), 32'd0);
            check("uncfg_all_loaded", 32'(all_loaded), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Load the reference tables
        cfg_write(0, 4'b0011);
        cfg_write(1, 4'b0111);
        cfg_write(2, 4'b1100);
        cfg_write(3, 4'b0001);
        cfg_write(4, 4'b0010);
        check("loaded_5_of_6", 32'(all_loaded), 32'd0);
        cfg_write(5, 4'b0101);
        check("loaded_6_of_6", 32'(all_loaded), 32'd1);

        // Reference results, back to back: one accept per cycle, one cycle latency
        c0 = cyc; o0 = n_out;
        eval_exp(0, 6'b101011);
        eval_exp(1, 6'b010011);
        eval_exp(2, 6'b100110);
        eval_exp(3, 6'b000100);
        check("throughput_cycles", 32'(cyc - c0), 32'd4);
        @(negedge clk); #1;
        check("latency_results", 32'(n_out - o0), 32'd4);
        @(posedge clk); #1;

        // Backpressure for three cycles
        out_ready = 1'b0;
        eval(1);
        hold_exp = model_f(1);
        in_valid = 1'b1; in_x = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_f", 32'(out_f), 32'(hold_exp));
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_cfg_ready", 32'(cfg_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        o0 = n_out;
        eval(2);
        eval(3);
        drain();
        check("bp_no_loss", 32'(n_out - o0), 32'd3);

        // Write and evaluate in the same cycle: write wins, eval sees new table
        cfg_valid = 1'b1; cfg_sel = 2; cfg_tt = 4'b0011;
        in_valid = 1'b1; in_x = 0;
        @(negedge clk);
        check("prio_cfg_ready", 32'(cfg_ready), 32'd1);
        check("prio_in_ready", 32'(in_ready), 32'd0);
        tbl[2] = 4'b0011;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        eval_exp(0, 6'b101111);
        check("prio_all_loaded", 32'(all_loaded), 32'd1);

        // Out-of-range select is ignored
        cfg_write(2, 4'b1100);
        cfg_write(7, 4'b1111);
        check("sel7_all_loaded", 32'(all_loaded), 32'd1);
        eval_exp(0, 6'b101011);
        drain();

        // Clear with a result pending and a write in the same cycle
        out_ready = 1'b0;
        eval(3);
        hold_exp = model_f(3);
        cfg_clr = 1'b1; cfg_valid = 1'b1; cfg_sel = 0; cfg_tt = 4'b1111;
        @(posedge clk); #1;
        cfg_clr = 1'b0; cfg_valid = 1'b0;
        for (int j = 0; j < 6; j++) tbl[j] = '0;
        in_valid = 1'b1; in_x = 0;
        @(negedge clk);
        check("clr_all_loaded", 32'(all_loaded), 32'd0);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        check("clr_keeps_valid", 32'(out_valid), 32'd1);
        check("clr_keeps_f", 32'(out_f), 32'(hold_exp));
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        // Reload; the write dropped by the clear must not count as loaded
        cfg_write(1, 4'b1000);
        cfg_write(2, 4'b0110);
        cfg_write(3, 4'b1110);
        cfg_write(4, 4'b1001);
        cfg_write(5, 4'b1010);
        check("clr_dropped_write", 32'(all_loaded), 32'd0);
        cfg_write(0, 4'b0100);
        check("reload_all_loaded", 32'(all_loaded), 32'd1);
        for (int x = 0; x < 4; x++) eval(2'(x));
        drain();

        // Reset with a result pending discards it
        out_ready = 1'b0;
        eval(1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_f", 32'(out_f), 32'd0);
        check("rst_mid_all_loaded", 32'(all_loaded), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drain();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
